// File: rtl/qslave_seq_pkg.sv
// Shared state encoding and default timing constants for the QBUS slave sequencer.
package qslave_seq_pkg;

  typedef enum logic [2:0] {
    QS_IDLE      = 3'd0,
    QS_RD_SETUP  = 3'd1,
    QS_RD_REPLY  = 3'd2,
    QS_VEC_SETUP = 3'd3,
    QS_VEC_REPLY = 3'd4,
    QS_WR_REPLY  = 3'd5,
    QS_RELEASE   = 3'd6
  } qs_state_t;

  localparam int QS_SETTLE_DEF  = 2;
  localparam int QS_TIMEOUT_DEF = 200;
  localparam int QS_SCNT_W      = 4;
  localparam int QS_TCNT_W      = 10;

endpackage

// File: rtl/qslave_seq_qsync2.sv
// Two-flop synchronizer for one async QBUS receiver line into the clk20 domain.
module qsync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/qslave_seq.sv
// QBUS slave-side sequencer: drives transceiver controls and TRPLY for DATI, DATO
// and interrupt-vector cycles, with settle delay, bus-cycle timeout and INIT abort.
module qslave_seq
  import qslave_seq_pkg::*;
#(
  parameter int SETTLE  = QS_SETTLE_DEF,
  parameter int TIMEOUT = QS_TIMEOUT_DEF
) (
  input  logic clk20,
  input  logic reset_L,
  input  logic RSYNC,
  input  logic RDIN,
  input  logic RDOUT,
  input  logic RINIT,
  input  logic addr_match,
  input  logic assert_vector,
  output logic TRPLY,
  output logic DALtx,
  output logic DALst,
  output logic DALbe,
  output logic wr_strobe,
  output logic rd_done,
  output logic busy,
  output logic timeout_err
);

  localparam int NSYNC = 6;

  logic [NSYNC-1:0] w_async, w_sync;
  logic w_srsync, w_srdin, w_srdout, w_srinit, w_saddr, w_svec;

  assign w_async = {RSYNC, RDIN, RDOUT, RINIT, addr_match, assert_vector};

  for (genvar g = 0; g < NSYNC; g++) begin : g_sync
    qsync2 u_sync (
      .i_clk   (clk20),
      .i_rst_n (reset_L),
      .i_d     (w_async[g]),
      .o_q     (w_sync[g])
    );
  end

  assign {w_srsync, w_srdin, w_srdout, w_srinit, w_saddr, w_svec} = w_sync;

  qs_state_t              r_state, w_next;
  logic [QS_SCNT_W-1:0]   r_scnt;
  logic [QS_TCNT_W-1:0]   r_tcnt;
  logic                   r_lock;
  logic                   w_tmo, w_abort, w_settled, w_setup;

  assign w_tmo     = (r_state != QS_IDLE) && (r_tcnt == QS_TCNT_W'(TIMEOUT - 1));
  assign w_abort   = w_srinit | w_tmo;
  assign w_settled = (r_scnt == QS_SCNT_W'(SETTLE - 1));
  assign w_setup   = (r_state == QS_RD_SETUP) || (r_state == QS_VEC_SETUP);

  // r_lock keeps a timed-out master from being re-served until it negates DIN/DOUT.
  always_ff @(posedge clk20 or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= QS_IDLE;
      r_scnt  <= '0;
      r_tcnt  <= '0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_setup && (w_next == r_state)) r_scnt <= r_scnt + QS_SCNT_W'(1);
      else                                r_scnt <= '0;
      if ((r_state == QS_IDLE) || (w_next == QS_IDLE))   r_tcnt <= '0;
      else if (r_tcnt != QS_TCNT_W'(TIMEOUT))            r_tcnt <= r_tcnt + QS_TCNT_W'(1);
      if (w_tmo)                      r_lock <= 1'b1;
      else if (!w_srdin && !w_srdout) r_lock <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = QS_IDLE;
    end else begin
      case (r_state)
        QS_IDLE: begin
          if (!r_lock) begin
            if (w_srsync && w_saddr && w_srdin)       w_next = QS_RD_SETUP;
            else if (w_srsync && w_saddr && w_srdout) w_next = QS_WR_REPLY;
            else if (!w_srsync && w_svec && w_srdin)  w_next = QS_VEC_SETUP;
          end
        end
        QS_RD_SETUP:  if (w_settled) w_next = QS_RD_REPLY;
        QS_VEC_SETUP: if (w_settled) w_next = QS_VEC_REPLY;
        QS_RD_REPLY,
        QS_VEC_REPLY: if (!w_srdin)  w_next = QS_RELEASE;
        QS_WR_REPLY:  if (!w_srdout) w_next = QS_RELEASE;
        QS_RELEASE:   if (!w_srdin && !w_srdout) w_next = QS_IDLE;
        default:      w_next = QS_IDLE;
      endcase
    end
  end

  // Aborts blank every control in the cycle they are detected, not one cycle later.
  always_comb begin
    TRPLY       = 1'b0;
    DALtx       = 1'b0;
    DALst       = 1'b0;
    DALbe       = 1'b0;
    wr_strobe   = 1'b0;
    rd_done     = 1'b0;
    busy        = (r_state != QS_IDLE);
    timeout_err = w_tmo;
    if (!w_abort) begin
      case (r_state)
        QS_RD_SETUP,
        QS_VEC_SETUP: DALtx = 1'b1;
        QS_RD_REPLY,
        QS_VEC_REPLY: begin
          TRPLY   = 1'b1;
          DALtx   = 1'b1;
          DALst   = 1'b1;
          DALbe   = 1'b1;
          rd_done = !w_srdin;
        end
        QS_WR_REPLY: begin
          TRPLY     = 1'b1;
          wr_strobe = (r_tcnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qslave_seq.sv
// Bench for qslave_seq: vector table for DATI/DATO/vector timing plus hand sequences
// for DATIO, timeout lockout, INIT abort and async reset; pulse scoreboard on the side.
module tb_qslave_seq;

  logic clk20 = 1'b0, reset_L = 1'b0;
  logic RSYNC = 0, RDIN = 0, RDOUT = 0, RINIT = 0, addr_match = 0, assert_vector = 0;
  logic TRPLY, DALtx, DALst, DALbe, wr_strobe, rd_done, busy, timeout_err;
  logic tTRPLY, tDALtx, tDALst, tDALbe, twr_strobe, trd_done, tbusy, ttimeout_err;

  always #25 clk20 = ~clk20;

  qslave_seq #(.SETTLE(2), .TIMEOUT(200)) u_dut (
    .clk20(clk20), .reset_L(reset_L), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
    .RINIT(RINIT), .addr_match(addr_match), .assert_vector(assert_vector),
    .TRPLY(TRPLY), .DALtx(DALtx), .DALst(DALst), .DALbe(DALbe), .wr_strobe(wr_strobe),
    .rd_done(rd_done), .busy(busy), .timeout_err(timeout_err));

  qslave_seq #(.SETTLE(2), .TIMEOUT(32)) u_tmo (
    .clk20(clk20), .reset_L(reset_L), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
    .RINIT(RINIT), .addr_match(addr_match), .assert_vector(assert_vector),
    .TRPLY(tTRPLY), .DALtx(tDALtx), .DALst(tDALst), .DALbe(tDALbe), .wr_strobe(twr_strobe),
    .rd_done(trd_done), .busy(tbusy), .timeout_err(ttimeout_err));

  wire [7:0] w_out  = {TRPLY, DALtx, DALst, DALbe, wr_strobe, rd_done, busy, timeout_err};
  wire [7:0] w_tout = {tTRPLY, tDALtx, tDALst, tDALbe, twr_strobe, trd_done, tbusy, ttimeout_err};

  localparam logic [7:0] O0 = 8'h00, OSET = 8'h42, ORPL = 8'hF2, ORD = 8'hF6;
  localparam logic [7:0] OWS = 8'h8A, OWR = 8'h82, OBSY = 8'h02;
  localparam int EV_R = 1, EV_W = 2;

  typedef struct {
    logic rs, rd, ro, am, av;
    int   n;
    logic [7:0] exp;
    int   ev;
  } vec_t;

  vec_t vt[$];
  int   exp_q[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk20);
      #5;
    end
  endtask

  task automatic drive(input logic rs, rd, ro, am, av);
    RSYNC = rs; RDIN = rd; RDOUT = ro; addr_match = am; assert_vector = av;
  endtask

  task automatic add(input logic rs, rd, ro, am, av, input int n, input logic [7:0] e, input int ev);
    vec_t v;
    v.rs = rs; v.rd = rd; v.ro = ro; v.am = am; v.av = av; v.n = n; v.exp = e; v.ev = ev;
    vt.push_back(v);
  endtask

  task automatic sb_pop(input int code, input string nm);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected pulse got=%0d exp=none", nm, code);
    end else begin
      e = exp_q.pop_front();
      if (e != code) begin
        failures++;
        $display("FAIL %s got=%0d exp=%0d", nm, code, e);
      end
    end
  endtask

  // Pulse scoreboard and per-cycle invariants on the main instance.
  always @(negedge clk20) begin
    if (reset_L) begin
      if (rd_done)     sb_pop(EV_R, "sb_rd_done");
      if (wr_strobe)   sb_pop(EV_W, "sb_wr_strobe");
      if (timeout_err) sb_pop(3, "sb_timeout");
      chk("inv_dalbe_daltx", {31'd0, DALbe & ~DALtx}, 0);
      chk("inv_rd_wr", {31'd0, rd_done & wr_strobe}, 0);
      chk("inv_trply_busy", {31'd0, TRPLY & ~busy}, 0);
    end
  end

  initial begin
    int n;
    logic [8:0] h_trply, h_rd, h_wr;

    // DATI
    add(0,0,0,0,0, 3, O0,   0);
    add(1,0,0,1,0, 3, O0,   0);
    add(1,1,0,1,0, 2, O0,   0);
    add(1,1,0,1,0, 1, OSET, 0);
    add(1,1,0,1,0, 1, OSET, 0);
    add(1,1,0,1,0, 1, ORPL, 0);
    add(1,1,0,1,0, 6, ORPL, 0);
    add(1,0,0,1,0, 2, ORD,  EV_R);
    add(1,0,0,1,0, 1, OBSY, 0);
    add(1,0,0,1,0, 1, O0,   0);
    add(0,0,0,0,0, 3, O0,   0);
    // DATO, long DOUT hold
    add(1,0,0,1,0, 3, O0,   0);
    add(1,0,1,1,0, 2, O0,   EV_W);
    add(1,0,1,1,0, 1, OWS,  0);
    add(1,0,1,1,0, 1, OWR,  0);
    add(1,0,1,1,0, 38, OWR, 0);
    add(1,0,0,1,0, 2, OWR,  0);
    add(1,0,0,1,0, 1, OBSY, 0);
    add(1,0,0,1,0, 1, O0,   0);
    add(0,0,0,0,0, 3, O0,   0);
    // vector read
    add(0,0,0,0,1, 3, O0,   0);
    add(0,1,0,0,1, 2, O0,   0);
    add(0,1,0,0,1, 1, OSET, 0);
    add(0,1,0,0,1, 1, OSET, 0);
    add(0,1,0,0,1, 1, ORPL, 0);
    add(0,1,0,0,1, 4, ORPL, 0);
    add(0,0,0,0,1, 2, ORD,  EV_R);
    add(0,0,0,0,1, 1, OBSY, 0);
    add(0,0,0,0,1, 1, O0,   0);
    // vector present while SYNC high and no address hit: ignored
    add(1,0,0,0,1, 3, O0,   0);
    add(1,1,0,0,1, 6, O0,   0);
    add(0,0,0,0,0, 3, O0,   0);
    // addr_match dropping mid-cycle is ignored
    add(1,1,0,1,0, 5, ORPL, 0);
    add(1,1,0,0,0, 4, ORPL, 0);
    add(1,0,0,0,0, 2, ORD,  EV_R);
    add(1,0,0,0,0, 1, OBSY, 0);
    add(0,0,0,0,0, 2, O0,   0);
    // DIN and DOUT together: read wins, RELEASE waits for both negated
    add(1,0,0,1,0, 3, O0,   0);
    add(1,1,1,1,0, 3, OSET, 0);
    add(1,1,1,1,0, 2, ORPL, 0);
    add(1,0,1,1,0, 2, ORD,  EV_R);
    add(1,0,1,1,0, 1, OBSY, 0);
    add(1,0,1,1,0, 3, OBSY, 0);
    add(1,0,0,1,0, 2, OBSY, 0);
    add(1,0,0,1,0, 1, O0,   0);
    add(0,0,0,0,0, 3, O0,   0);

    // reset state, with bus activity present during reset
    drive(1,1,0,1,0);
    cyc(3);
    chk("reset_state", w_out, O0);
    chk("reset_state_tmo", w_tout, O0);
    drive(0,0,0,0,0);
    cyc(3);
    reset_L = 1'b1;
    cyc(1);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rs, vt[i].rd, vt[i].ro, vt[i].am, vt[i].av);
      if (vt[i].ev != 0) exp_q.push_back(vt[i].ev);
      cyc(vt[i].n);
      chk($sformatf("vec%0d", i), w_out, vt[i].exp);
    end

    // DATIO: rd_done, idle gap, then a fresh write reply
    drive(1,0,0,1,0); cyc(3);
    RDIN = 1; exp_q.push_back(EV_R); exp_q.push_back(EV_W);
    cyc(10);
    RDIN = 0;
    h_trply = '0; h_rd = '0; h_wr = '0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      h_trply[k] = TRPLY; h_rd[k] = rd_done; h_wr[k] = wr_strobe;
      if (k == 2) RDOUT = 1;
    end
    chk("datio_trply", h_trply, 9'b111100110);
    chk("datio_rd_done", h_rd, 9'b000000100);
    chk("datio_wr_strobe", h_wr, 9'b000100000);
    RDOUT = 0; cyc(4);
    drive(0,0,0,0,0); cyc(3);

    // timeout on the TIMEOUT=32 instance, then lockout until DIN re-asserts
    drive(1,0,0,1,0); cyc(3);
    RDIN = 1; cyc(3);
    chk("tmo_enter", {31'd0, tbusy}, 1);
    n = 1;
    while (!ttimeout_err && n < 100) begin
      cyc(1);
      n++;
    end
    chk("tmo_cycle", n, 32);
    chk("tmo_pulse", w_tout, 8'h03);
    cyc(1);
    chk("tmo_idle", w_tout, O0);
    cyc(10);
    chk("tmo_lock", w_tout, O0);
    RDIN = 0; exp_q.push_back(EV_R); cyc(4);
    RDIN = 1; cyc(5);
    chk("tmo_rearm", w_tout, ORPL);
    RDIN = 0; exp_q.push_back(EV_R); cyc(4);
    drive(0,0,0,0,0); cyc(3);

    // INIT mid read reply: outputs drop, no rd_done
    drive(1,0,0,1,0); cyc(3);
    RDIN = 1; cyc(6);
    chk("rinit_pre", w_out, ORPL);
    RINIT = 1; cyc(3);
    chk("rinit_drop", w_out, O0);
    drive(0,0,0,0,0); cyc(4);
    chk("rinit_hold", w_out, O0);
    RINIT = 0; cyc(4);
    chk("rinit_after", w_out, O0);

    // async reset mid write reply
    drive(1,0,0,1,0); cyc(3);
    RDOUT = 1; exp_q.push_back(EV_W); cyc(4);
    chk("rst_pre", w_out, OWR);
    #1 reset_L = 1'b0;
    #1 chk("rst_async", w_out, O0);
    drive(0,0,0,0,0); cyc(3);
    reset_L = 1'b1; cyc(3);
    chk("rst_after", w_out, O0);

    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qslave_seq.md
Name: qslave_seq

Overview:
- Synchronous sequencer for the QBUS slave side of the QSIC.
- Drives the Am2908 transceiver controls and TRPLY for three cycle types: DATI register reads, DATO register writes and interrupt-vector reads.
- Sits between the async QBUS receivers and the device register mux (switch register, RKV11, later devices), in the clk20 domain.
- Alongside it, the DMA master owns the same transceivers; the top level ORs both control sets.

Parameters:
- SETTLE, 2: clk20 cycles that DALtx is held before DALbe/DALst/TRPLY assert. Covers ribbon-cable settling. Legal range 1..15.
- TIMEOUT, 200: clk20 cycles a reply state may persist before abort (10 us). Legal range 16..1023.

Ports:
- clk20  in  1  20 MHz QBUS clock
- reset_L  in  1  asynchronous, active-low reset
- RSYNC  in  1  async, bus SYNC
- RDIN  in  1  async, bus DIN
- RDOUT  in  1  async, bus DOUT
- RINIT  in  1  async, bus INIT
- addr_match  in  1  async; the latched address hits one of our registers
- assert_vector  in  1  async; an interrupt source is presenting its vector
- TRPLY  out  1  bus RPLY
- DALtx  out  1  transceivers and level shifters point toward the bus
- DALst  out  1  transceiver output latch strobe (level, transparent while high)
- DALbe  out  1  transceiver bus enable (active high; top level inverts to DALbe_L)
- wr_strobe  out  1  one-cycle pulse: RDL is valid, the register write must commit
- rd_done  out  1  one-cycle pulse at the end of a DATI or vector read (for read side effects)
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse when a cycle is aborted by TIMEOUT

Behaviour:
- Synchronization:
  - RSYNC, RDIN, RDOUT, RINIT, addr_match and assert_vector each pass through a 2-FF synchronizer.
  - The FSM only uses the synchronized signals s*.
  - Synchronizer FFs reset to 0.
- Reset (reset_L low, async): state=IDLE, counters=0, all outputs 0.
- sRINIT high, synchronous: force IDLE next cycle and drop all outputs. No wr_strobe or rd_done is issued.
- States:
  - IDLE: all outputs 0.
    - sRSYNC & saddr_match & sRDIN -> RD_SETUP.
    - sRSYNC & saddr_match & sRDOUT -> WR_REPLY.
    - !sRSYNC & sassert_vector & sRDIN -> VEC_SETUP.
    - Priority: RD_SETUP > WR_REPLY > VEC_SETUP.
  - RD_SETUP / VEC_SETUP: DALtx=1, counter increments. At counter==SETTLE-1 -> RD_REPLY / VEC_REPLY. The counter clears on the transition.
  - RD_REPLY / VEC_REPLY: DALtx=DALbe=DALst=TRPLY=1. Hold until sRDIN=0, then -> RELEASE with rd_done pulsed in that same cycle.
  - WR_REPLY: TRPLY=1.
    - wr_strobe pulses exactly once, on the first cycle in the state.
    - Hold until sRDOUT=0, then -> RELEASE.
  - RELEASE: all outputs 0. Wait for sRDIN=0 & sRDOUT=0, then -> IDLE. Guarantees one idle cycle between bus cycles.
- Latency:
  - Bus RDIN edge to TRPLY = 2 (sync) + 1 (IDLE decode) + SETTLE cycles. Default 5 cycles = 250 ns.
  - Bus RDOUT edge to TRPLY = 3 cycles.
- DATIO: RDIN then RDOUT under the same SYNC. RELEASE returns to IDLE, which re-decodes sRDOUT and enters WR_REPLY. The sequence is legal and produces rd_done then wr_strobe.
- saddr_match dropping mid-cycle is ignored once the FSM is past IDLE. The cycle completes on the DIN/DOUT negation only.
- Timeout:
  - A cycle counter runs in every non-IDLE state.
  - Reaching TIMEOUT forces IDLE, pulses timeout_err and drops all outputs.
  - The counter is 10 bits wide and never wraps; it saturates at TIMEOUT.
- Invariants:
  - DALbe=1 implies DALtx=1, every cycle.
  - DALtx falls no earlier than DALbe.
  - TRPLY never asserts in IDLE or RELEASE.
  - wr_strobe and rd_done are never both asserted in the same cycle.

Decomposition:
- Shared package/header (qsic.vh): state encoding defines QS_IDLE, QS_RD_SETUP, QS_RD_REPLY, QS_VEC_SETUP, QS_VEC_REPLY, QS_WR_REPLY, QS_RELEASE (3-bit) and default SETTLE/TIMEOUT constants.
- One sub-module, qsync2: a 2-FF synchronizer with async active-low reset, instantiated six times.

Test Plan:
- DATI, SETTLE=2: addr_match=1, RSYNC then RDIN at t0.
  - DALtx rises at t0+3 cycles.
  - TRPLY/DALbe/DALst rise at t0+5.
  - Drop RDIN: all outputs 0 within 3 cycles, with rd_done=1 for exactly one cycle.
- DATO: RSYNC and RDOUT asserted.
  - TRPLY at t0+3 with wr_strobe exactly 1 cycle coincident.
  - RDOUT held 40 cycles -> no second wr_strobe.
  - Release -> TRPLY 0 after 3 cycles.
- Vector read: RSYNC=0, assert_vector=1, RDIN.
  - Same timing as DATI.
  - If assert_vector=1 with RSYNC=1 and addr_match=0 -> FSM stays IDLE.
- DATIO: RDIN high 10 cycles, low 2 cycles, then RDOUT high.
  - Order is rd_done, at least one idle cycle, TRPLY reasserted, wr_strobe.
- Timeout, TIMEOUT=32: RDIN held high forever.
  - timeout_err pulses at cycle 32 after leaving IDLE and outputs drop.
  - FSM remains IDLE until RDIN falls and rises again.
- Aborts:
  - RINIT asserted mid-RD_REPLY -> outputs 0 within 3 cycles, no rd_done.
  - reset_L low mid-WR_REPLY -> outputs 0 immediately, combinationally via async reset.
